// File: rtl/motor_spi_sequencer.sv
// Snapshots the left/right wheel dps commands and streams two SET_MOTOR_DPS
// frames (left, then right) to the SPI byte master while owning chip select.
module motor_spi_sequencer #(
   parameter int         nb_dps_motor = 16,
   parameter int         nb_period    = 20,
   parameter int         nb_gap       = 3,
   parameter logic [7:0] c_addr       = 8'h08,
   parameter logic [7:0] c_msg_dps    = 8'h0A,
   parameter logic [7:0] c_port_left  = 8'h01,
   parameter logic [7:0] c_port_rght  = 8'h02
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic [nb_dps_motor-1:0] motor_dps_left_i,
   input  logic [nb_dps_motor-1:0] motor_dps_rght_i,
   output logic [7:0]              byte_o,
   output logic                    byte_valid_o,
   input  logic                    byte_ready_i,
   input  logic                    spi_busy_i,
   output logic                    cs_n_o,
   output logic                    busy_o,
   output logic [7:0]              frames_sent_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LATCH     = 3'd1,
      S_CS_SETUP  = 3'd2,
      S_SEND      = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_CS_GAP    = 3'd5
   } state_t;

   localparam logic [nb_gap-1:0]    gap_one     = {{(nb_gap-1){1'b0}}, 1'b1};
   localparam logic [nb_period-1:0] refresh_one = {{(nb_period-1){1'b0}}, 1'b1};

   state_t                  state, state_nxt;
   logic [2:0]              idx, idx_nxt;
   logic                    motor_rght, motor_rght_nxt;
   logic [nb_gap-1:0]       gap_cnt, gap_nxt;
   logic [nb_period-1:0]    refresh_cnt, refresh_nxt;
   logic                    pending, pending_nxt;
   logic [nb_dps_motor-1:0] last_left, last_left_nxt, last_rght, last_rght_nxt;
   logic [nb_dps_motor-1:0] snap_left, snap_left_nxt, snap_rght, snap_rght_nxt;
   logic [nb_dps_motor-1:0] eff_left, eff_rght, sel_value;
   logic [7:0]              byte_nxt, frames_nxt;
   logic                    valid_nxt, cs_n_nxt, busy_nxt;
   logic                    refresh_hit, req_now;

   function automatic logic [7:0] frame_byte(input logic [2:0] index, input logic rght,
                                             input logic [nb_dps_motor-1:0] value);
      logic [7:0] result;
      result = 8'h00;
      case (index)
         3'd0:    result = c_addr;
         3'd1:    result = c_msg_dps;
         3'd2:    result = rght ? c_port_rght : c_port_left;
         3'd3:    result = value[15:8];
         3'd4:    result = value[7:0];
         default: result = 8'h00;
      endcase
      return result;
   endfunction

   assign eff_left    = enable ? motor_dps_left_i : {nb_dps_motor{1'b0}};
   assign eff_rght    = enable ? motor_dps_rght_i : {nb_dps_motor{1'b0}};
   assign refresh_hit = enable & (&refresh_cnt);
   // A request seen this cycle lets IDLE leave on the very next edge.
   assign req_now     = (eff_left != last_left) | (eff_rght != last_rght) | refresh_hit;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_nxt      = state;
      idx_nxt        = idx;
      motor_rght_nxt = motor_rght;
      gap_nxt        = gap_cnt;
      frames_nxt     = frames_sent_o;
      pending_nxt    = pending | req_now;
      last_left_nxt  = last_left;
      last_rght_nxt  = last_rght;
      snap_left_nxt  = snap_left;
      snap_rght_nxt  = snap_rght;
      byte_nxt       = byte_o;
      sel_value      = snap_left;

      case (state)
         S_IDLE: begin
            if (pending || req_now) begin
               state_nxt = S_LATCH;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_LATCH: begin
            snap_left_nxt  = eff_left;
            snap_rght_nxt  = eff_rght;
            last_left_nxt  = eff_left;
            last_rght_nxt  = eff_rght;
            pending_nxt    = 1'b0;
            motor_rght_nxt = 1'b0;
            state_nxt      = S_CS_SETUP;
         end
         S_CS_SETUP: begin
            idx_nxt   = 3'd0;
            state_nxt = S_SEND;
         end
         S_SEND: begin
            if (byte_ready_i) begin
               if (idx == 3'd4) begin
                  state_nxt = S_WAIT_DONE;
               end else begin
                  idx_nxt = idx + 3'd1;
               end
            end else begin
               state_nxt = S_SEND;
            end
         end
         S_WAIT_DONE: begin
            if (!spi_busy_i) begin
               frames_nxt = frames_sent_o + 8'd1;
               gap_nxt    = {nb_gap{1'b0}};
               state_nxt  = S_CS_GAP;
            end else begin
               state_nxt = S_WAIT_DONE;
            end
         end
         S_CS_GAP: begin
            if (&gap_cnt) begin
               if (!motor_rght) begin
                  motor_rght_nxt = 1'b1;
                  state_nxt      = S_CS_SETUP;
               end else begin
                  state_nxt = S_IDLE;
               end
            end else begin
               gap_nxt = gap_cnt + gap_one;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      valid_nxt = (state_nxt == S_SEND);
      cs_n_nxt  = !(state_nxt inside {S_CS_SETUP, S_SEND, S_WAIT_DONE});
      busy_nxt  = (state_nxt != S_IDLE);

      // Load the byte for the index that will be presented next, so bytes chain without bubbles.
      if (state_nxt == S_SEND) begin
         sel_value = motor_rght_nxt ? snap_rght : snap_left;
         byte_nxt  = frame_byte(idx_nxt, motor_rght_nxt, sel_value);
      end else begin
         byte_nxt = byte_o;
      end

      if (state_nxt == S_LATCH) begin
         refresh_nxt = {nb_period{1'b0}};
      end else begin
         refresh_nxt = refresh_cnt + refresh_one;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         idx           <= 3'd0;
         motor_rght    <= 1'b0;
         gap_cnt       <= {nb_gap{1'b0}};
         refresh_cnt   <= {nb_period{1'b0}};
         pending       <= 1'b0;
         last_left     <= {nb_dps_motor{1'b0}};
         last_rght     <= {nb_dps_motor{1'b0}};
         snap_left     <= {nb_dps_motor{1'b0}};
         snap_rght     <= {nb_dps_motor{1'b0}};
         byte_o        <= 8'h00;
         byte_valid_o  <= 1'b0;
         cs_n_o        <= 1'b1;
         busy_o        <= 1'b0;
         frames_sent_o <= 8'd0;
      end else begin
         state         <= state_nxt;
         idx           <= idx_nxt;
         motor_rght    <= motor_rght_nxt;
         gap_cnt       <= gap_nxt;
         refresh_cnt   <= refresh_nxt;
         pending       <= pending_nxt;
         last_left     <= last_left_nxt;
         last_rght     <= last_rght_nxt;
         snap_left     <= snap_left_nxt;
         snap_rght     <= snap_rght_nxt;
         byte_o        <= byte_nxt;
         byte_valid_o  <= valid_nxt;
         cs_n_o        <= cs_n_nxt;
         busy_o        <= busy_nxt;
         frames_sent_o <= frames_nxt;
      end
   end

endmodule

// File: tb/tb_motor_spi_sequencer.sv
// Scoreboard bench: stimulus pushes the expected SPI byte stream, monitors pop and compare.
module tb_motor_spi_sequencer;

   logic        clk;
   logic        rst;
   logic        enable;
   logic [15:0] left_cmd, rght_cmd;
   logic [7:0]  byte_o;
   logic        byte_valid_o, byte_ready_i, spi_busy_i, cs_n_o, busy_o;
   logic [7:0]  frames_sent_o;

   logic        en2;
   logic [15:0] left2, rght2;
   logic [7:0]  byte2, frames2;
   logic        valid2, cs2, busy2;
   logic        ready2 = 1'b1;
   logic        sbusy2 = 1'b0;

   logic [7:0]  q[$];
   logic [7:0]  q2[$];
   int          rises2[$];
   int          checks = 0, passes = 0, fails = 0;
   int          busy_len = 0, ready_mode = 0, stall_left = 0, stall_seen = 0;
   int          exp_frames = 0, cyc = 0, cyc2 = 0, valid2_cnt = 0;
   logic [15:0] cur_l, cur_r;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   motor_spi_sequencer u_dut (
      .clk(clk), .rst(rst), .enable(enable),
      .motor_dps_left_i(left_cmd), .motor_dps_rght_i(rght_cmd),
      .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
      .spi_busy_i(spi_busy_i), .cs_n_o(cs_n_o), .busy_o(busy_o), .frames_sent_o(frames_sent_o));

   motor_spi_sequencer #(.nb_period(6)) u_ref (
      .clk(clk), .rst(rst), .enable(en2),
      .motor_dps_left_i(left2), .motor_dps_rght_i(rght2),
      .byte_o(byte2), .byte_valid_o(valid2), .byte_ready_i(ready2),
      .spi_busy_i(sbusy2), .cs_n_o(cs2), .busy_o(busy2), .frames_sent_o(frames2));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) begin
         passes++;
      end else begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: each pair is left frame then right frame, 5 bytes each, value MSB first.
   task automatic push_pair(input bit to_ref, input logic [15:0] l, input logic [15:0] r);
      logic [15:0] v;
      logic [7:0]  frame[5];
      for (int m = 0; m < 2; m++) begin
         v = (m == 0) ? l : r;
         frame[0] = 8'h08;
         frame[1] = 8'h0A;
         frame[2] = (m == 0) ? 8'h01 : 8'h02;
         frame[3] = v[15:8];
         frame[4] = v[7:0];
         for (int k = 0; k < 5; k++) begin
            if (to_ref) q2.push_back(frame[k]);
            else        q.push_back(frame[k]);
         end
      end
      if (!to_ref) exp_frames += 2;
   endtask

   task automatic wait_quiet(input int budget);
      int  n = 0, quiet = 0;
      bit  started = 0;
      while (n < budget && !(started && quiet >= 3)) begin
         @(negedge clk);
         n++;
         if (busy_o) begin
            started = 1;
            quiet   = 0;
         end else begin
            quiet++;
         end
      end
      check("pair_complete", {31'd0, started && quiet >= 3}, 32'd1);
   endtask

   // SPI master model: takes bytes, then stays busy busy_len cycles after the fifth.
   initial begin
      int  busy_cnt = 0, drv_pos = 0;
      bit  acc_prev = 0;
      byte_ready_i = 1'b0;
      spi_busy_i   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt = 0; drv_pos = 0; acc_prev = 0;
            spi_busy_i = 1'b0; byte_ready_i = 1'b0;
         end else begin
            if (busy_cnt > 0) busy_cnt--;
            if (acc_prev) begin
               if (drv_pos == 4) begin
                  busy_cnt = busy_len;
                  drv_pos  = 0;
               end else begin
                  drv_pos++;
               end
            end
            spi_busy_i = (busy_cnt != 0);
            if (stall_left > 0 && byte_valid_o && drv_pos == 3) begin
               byte_ready_i = 1'b0;
               stall_left--;
            end else if (ready_mode == 1) begin
               byte_ready_i = ($urandom_range(0, 3) != 0);
            end else begin
               byte_ready_i = 1'b1;
            end
            acc_prev = byte_valid_o && byte_ready_i;
         end
      end
   end

   // Main monitor: pops on accepted bytes, checks held bytes and CS release latency.
   initial begin
      int  mon_pos = 0, last5 = 0;
      logic cs_prev = 1'b1;
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (rst) begin
            mon_pos = 0;
            cs_prev = 1'b1;
         end else begin
            if (byte_valid_o) begin
               check("byte_expected", {31'd0, q.size() != 0}, 32'd1);
               if (q.size() != 0) begin
                  check("cs_low_while_valid", {31'd0, cs_n_o}, 32'd0);
                  if (byte_ready_i) begin
                     exp_b = q.pop_front();
                     check("byte", {24'd0, byte_o}, {24'd0, exp_b});
                     if (mon_pos == 4) begin
                        last5   = cyc;
                        mon_pos = 0;
                     end else begin
                        mon_pos++;
                     end
                  end else begin
                     check("held_byte", {24'd0, byte_o}, {24'd0, q[0]});
                     stall_seen++;
                  end
               end
            end
            // Fifth byte taken at the edge after last5; CS rises busy_len+1 edges later.
            if (!cs_prev && cs_n_o) check("cs_rise_latency", cyc - last5, busy_len + 2);
            cs_prev = cs_n_o;
         end
      end
   end

   // Refresh-instance monitor.
   initial begin
      logic b_prev = 1'b0;
      logic [7:0] exp_b;
      forever begin
         @(negedge clk);
         #1;
         cyc2++;
         if (!rst) begin
            if (valid2) begin
               valid2_cnt++;
               check("ref_byte_expected", {31'd0, q2.size() != 0}, 32'd1);
               if (q2.size() != 0) begin
                  exp_b = q2.pop_front();
                  check("ref_byte", {24'd0, byte2}, {24'd0, exp_b});
               end
            end
            if (busy2 && !b_prev) rises2.push_back(cyc2);
            b_prev = busy2;
         end
      end
   end

   initial begin
      int n, lo, bhi, clo, snap_cnt;
      rst = 1'b1; enable = 1'b0; left_cmd = 16'd0; rght_cmd = 16'd0;
      en2 = 1'b0; left2 = 16'd0; rght2 = 16'd0;
      repeat (3) @(negedge clk);
      check("rst_byte", {24'd0, byte_o}, 32'd0);
      check("rst_valid", {31'd0, byte_valid_o}, 32'd0);
      check("rst_cs_n", {31'd0, cs_n_o}, 32'd1);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_frames", {24'd0, frames_sent_o}, 32'd0);
      check("rst_ref_cs_n", {31'd0, cs2}, 32'd1);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Basic pair with ready=1 and no busy: latency and pair length.
      cur_l = 16'd600; cur_r = 16'd450;
      push_pair(0, cur_l, cur_r);
      enable = 1'b1; left_cmd = cur_l; rght_cmd = cur_r;
      @(negedge clk);
      check("latch_busy", {31'd0, busy_o}, 32'd1);
      check("latch_cs_n", {31'd0, cs_n_o}, 32'd1);
      @(negedge clk);
      check("setup_cs_n", {31'd0, cs_n_o}, 32'd0);
      check("setup_valid", {31'd0, byte_valid_o}, 32'd0);
      @(negedge clk);
      check("first_valid", {31'd0, byte_valid_o}, 32'd1);
      check("first_byte", {24'd0, byte_o}, 32'h08);
      bhi = 3; clo = 2; n = 0;
      while (busy_o && n < 100) begin
         @(negedge clk);
         n++;
         if (busy_o) bhi++;
         if (busy_o && !cs_n_o) clo++;
      end
      check("pair_cycles", bhi, 32'd31);
      check("cs_low_cycles", clo, 32'd14);
      check("frames_after_pair", {24'd0, frames_sent_o}, exp_frames % 256);

      // Ready stall of 10 cycles while byte 3 is presented.
      stall_seen = 0; stall_left = 10;
      cur_l = 16'($urandom_range(0, 599)); cur_r = 16'($urandom);
      push_pair(0, cur_l, cur_r);
      left_cmd = cur_l; rght_cmd = cur_r;
      wait_quiet(300);
      check("stall_cycles", stall_seen, 32'd10);
      check("frames_after_stall", {24'd0, frames_sent_o}, exp_frames % 256);

      // Mid-pair change: current pair keeps 600, a second pair follows with -250.
      cur_l = 16'd600;
      push_pair(0, cur_l, cur_r);
      push_pair(0, 16'hFF06, cur_r);
      left_cmd = cur_l;
      n = 0;
      while (cs_n_o && n < 50) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      cur_l = 16'hFF06; left_cmd = cur_l;
      n = 0;
      while (busy_o && n < 100) begin @(negedge clk); n++; end
      lo = 0;
      while (!busy_o && lo < 10) begin @(negedge clk); lo++; end
      check("idle_between_pairs", lo, 32'd1);
      wait_quiet(200);
      check("frames_after_change", {24'd0, frames_sent_o}, exp_frames % 256);

      // SPI master still shifting for 7 cycles after the fifth byte.
      busy_len = 7;
      cur_l = 16'($urandom); cur_r = 16'($urandom);
      if (cur_l == 16'hFF06) cur_l = 16'h1234;
      push_pair(0, cur_l, cur_r);
      left_cmd = cur_l; rght_cmd = cur_r;
      wait_quiet(400);
      check("frames_after_busy", {24'd0, frames_sent_o}, exp_frames % 256);

      // Randomized commands, ready and busy stretch.
      ready_mode = 1;
      for (int it = 0; it < 8; it++) begin
         logic [15:0] nl, nr;
         busy_len = $urandom_range(0, 4);
         nl = 16'($urandom); nr = 16'($urandom);
         if (nl == cur_l && nr == cur_r) nl = nl ^ 16'h0001;
         cur_l = nl; cur_r = nr;
         push_pair(0, cur_l, cur_r);
         left_cmd = cur_l; rght_cmd = cur_r;
         wait_quiet(800);
         check("frames_random", {24'd0, frames_sent_o}, exp_frames % 256);
      end

      // Asynchronous reset in the middle of SEND abandons the frame.
      ready_mode = 0; busy_len = 0;
      cur_l = cur_l ^ 16'h00F0;
      push_pair(0, cur_l, cur_r);
      left_cmd = cur_l;
      n = 0;
      while (!byte_valid_o && n < 50) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_cs_n", {31'd0, cs_n_o}, 32'd1);
      check("arst_valid", {31'd0, byte_valid_o}, 32'd0);
      check("arst_busy", {31'd0, busy_o}, 32'd0);
      check("arst_frames", {24'd0, frames_sent_o}, 32'd0);
      q.delete();
      exp_frames = 0;
      repeat (2) @(negedge clk);
      push_pair(0, cur_l, cur_r);
      rst = 1'b0;
      wait_quiet(300);
      check("frames_after_reset", {24'd0, frames_sent_o}, exp_frames % 256);
      check("main_queue_drained", q.size(), 32'd0);

      // Periodic refresh every 64 cycles, then one stop pair when enable drops.
      for (int p = 0; p < 4; p++) push_pair(1, 16'd100, 16'hFFF9);
      left2 = 16'd100; rght2 = 16'hFFF9; en2 = 1'b1;
      n = 0;
      while (rises2.size() < 4 && n < 400) begin @(negedge clk); n++; end
      check("ref_refresh_seen", {31'd0, rises2.size() >= 4}, 32'd1);
      if (rises2.size() >= 4) begin
         for (int i = 0; i < 3; i++) check("ref_refresh_interval", rises2[i+1] - rises2[i], 32'd64);
      end
      n = 0;
      while (busy2 && n < 100) begin @(negedge clk); n++; end
      push_pair(1, 16'd0, 16'd0);
      en2 = 1'b0;
      n = 0;
      while ((q2.size() != 0 || busy2 || n < 3) && n < 200) begin @(negedge clk); n++; end
      check("ref_stop_pair_done", q2.size(), 32'd0);
      snap_cnt = valid2_cnt;
      repeat (500) @(negedge clk);
      check("ref_silent_disabled", valid2_cnt - snap_cnt, 32'd0);
      check("ref_frames", {24'd0, frames2}, 32'd10);
      check("ref_busy_idle", {31'd0, busy2}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/motor_spi_sequencer.md
# motor_spi_sequencer

Sequences SPI write transactions that deliver the left/right wheel speed commands (degrees per second) from the motor controller to the GoPiGo3 motor board. The block snapshots both speed words, builds two 5-byte SET_MOTOR_DPS frames (left, then right), and feeds them byte by byte to the existing SPI byte master while owning the chip select. It sits between the motor controller outputs and the SPI byte master. Transmission is triggered by a command change or a periodic refresh.

## Interface
- nb_dps_motor, 16, width of each dps command word; must be 16
- nb_period, 20, width of the refresh counter; refresh interval is 2^nb_period cycles
- nb_gap, 3, width of the CS-high gap counter; the gap is 2^nb_gap cycles
- c_addr, 8'h08, GoPiGo3 SPI address byte
- c_msg_dps, 8'h0A, SET_MOTOR_DPS message-type byte
- c_port_left, 8'h01, left motor port byte
- c_port_rght, 8'h02, right motor port byte

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-high
- enable  in  1  when 0, effective commands are forced to 0 and periodic refresh is suppressed
- motor_dps_left_i  in  16  signed left command
- motor_dps_rght_i  in  16  signed right command
- byte_o  out  8  byte presented to the SPI master
- byte_valid_o  out  1  byte_o is valid
- byte_ready_i  in  1  SPI master accepts byte_o on this edge when byte_valid_o is 1
- spi_busy_i  in  1  SPI master is still shifting
- cs_n_o  out  1  GoPiGo3 chip select, active-low
- busy_o  out  1  a frame pair is in progress
- frames_sent_o  out  8  count of completed frames, wraps 255->0

## Operation
- Effective commands:
  - eff_left = enable ? motor_dps_left_i : 0
  - eff_rght = enable ? motor_dps_rght_i : 0
- last_left and last_rght hold the most recently snapshotted values. Both reset to 0.
- A pending flag is set on any cycle with (eff_left != last_left) or (eff_rght != last_rght).
- A pending flag is also set when the refresh counter reaches all-ones while enable=1.
- The refresh counter increments every cycle. It clears on reset and on entry to LATCH. It never raises a refresh request while enable=0.
- States:
  - IDLE: cs_n_o=1, busy_o=0. Moves to LATCH when pending=1.
  - LATCH: copies eff_left/eff_rght into snap_left/snap_rght and into last_left/last_rght. Clears pending, selects motor=left, busy_o=1, then moves to CS_SETUP.
  - CS_SETUP: drives cs_n_o=0 for one cycle, sets byte index=0, then moves to SEND.
  - SEND: byte_valid_o=1. byte_o by index is 0:c_addr, 1:c_msg_dps, 2:port of the selected motor, 3:snap[15:8], 4:snap[7:0].
    - On byte_ready_i=1 the index increments.
    - After index 4 is accepted, moves to WAIT_DONE.
  - WAIT_DONE: byte_valid_o=0. Waits until spi_busy_i=0, then sets cs_n_o=1, increments frames_sent_o, and moves to CS_GAP.
  - CS_GAP: counts 2^nb_gap cycles with cs_n_o=1.
    - If motor=left: selects right and moves to CS_SETUP.
    - Otherwise: moves to IDLE.
- Changes that arrive mid-pair set pending but do not alter the snapshot. The pair always completes with coherent snapped values. A new pair starts from IDLE on the cycle after CS_GAP ends.
- When enable falls, the effective commands become 0. This produces exactly one stop pair (0,0), provided the last values were nonzero. No further traffic follows while disabled.
- byte_o holds its value and byte_valid_o stays high until accepted. byte_ready_i is ignored when byte_valid_o=0.
- Asynchronous reset mid-frame returns to IDLE immediately: cs_n_o=1 and byte_valid_o=0. The partially sent frame is abandoned.

## Timing
- Reset values: byte_o=0, byte_valid_o=0, cs_n_o=1, busy_o=0, frames_sent_o=0, state=IDLE, pending=0, refresh counter=0.
- The cycle after pending first rises: LATCH. The following cycle: cs_n_o=0 (CS_SETUP). One cycle later: byte_valid_o=1 with c_addr.
- With byte_ready_i held at 1, the five bytes are accepted on five consecutive edges. byte_valid_o stays high across the bytes with no bubble.
- cs_n_o rises on the edge that samples spi_busy_i=0 in WAIT_DONE. frames_sent_o increments on that same edge.
- Minimum pair length with ready=1 and busy=0: 1 + 2×(1+5+1+2^nb_gap) cycles.
- Negative commands are sent as 16-bit two's complement, MSB first. -250 is sent as 8'hFF, 8'h06.

## Test plan
- Reset, then left=600 and right=450 with enable=1 and ready=1. Expect byte sequence 08 0A 01 02 58, CS high gap, then 08 0A 02 01 C2. frames_sent_o=2, busy_o=0 afterwards.
- Hold byte_ready_i=0 for 10 cycles in the middle of byte 3. Expect byte_o stable at snap[15:8] and byte_valid_o=1 throughout. The stream resumes with no lost or duplicated byte.
- Change left from 600 to -250 during the first frame. Expect the current pair to carry 600. A second pair follows immediately, with left bytes FF 06.
- Constant commands, nb_period=6. Expect a refresh pair every 64 cycles counted from LATCH. Drop enable: expect exactly one pair of zeros (00 00) and then no traffic for 500 cycles.
- Hold spi_busy_i=1 for 7 cycles after the fifth byte. Expect cs_n_o to stay low until busy falls.
- Assert rst during SEND. Expect cs_n_o=1 and byte_valid_o=0 immediately, and state IDLE.
